// File: rtl/id_stage.sv
// IF/ID register plus branch/jump resolution; 1-cycle F->D latency, StallD holds, FlushD/redirect insert bubbles.
// Build with DELAY_SLOT_EN to let the instruction after a redirect enter D (MIPS delay slot).
module id_stage #(
  parameter logic [31:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ALUOutM,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  output logic [31:0] ImmExtD,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic        JumpD,
  output logic [31:0] PCJumpD,
  output logic        JRD,
  output logic [31:0] PCJRD
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_beq, is_bne;
  logic [31:0] src_a, src_b;

  assign op    = instr_q[31:26];
  assign funct = instr_q[5:0];

  // Control decode is gated by the valid bit so bubbles never redirect fetch.
  assign is_beq = valid_q && (op == OP_BEQ);
  assign is_bne = valid_q && (op == OP_BNE);
  assign JumpD  = valid_q && ((op == OP_J) || (op == OP_JAL));
  assign JRD    = valid_q && (op == OP_RTYPE) && (funct == FN_JR);

  assign src_a = ForwardAD ? ALUOutM : RD1D;
  assign src_b = ForwardBD ? ALUOutM : RD2D;

  assign PCSrcD    = (is_beq && (src_a == src_b)) || (is_bne && (src_a != src_b));
  assign ImmExtD   = {{16{instr_q[15]}}, instr_q[15:0]};
  assign PCBranchD = pcp4_q + {ImmExtD[29:0], 2'b00};
  assign PCJumpD   = {pcp4_q[31:28], instr_q[25:0], 2'b00};
  assign PCJRD     = src_a;

  assign InstrD   = instr_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
  assign RsD      = instr_q[25:21];
  assign RtD      = instr_q[20:16];
  assign RdD      = instr_q[15:11];

`ifndef DELAY_SLOT_EN
  logic redirect;
  assign redirect = PCSrcD || JumpD || JRD;
`endif

  always_comb begin
    instr_d = InstrF;
    pcp4_d  = PCPlus4F;
    valid_d = 1'b1;
    if (FlushD) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else if (StallD) begin
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
`ifndef DELAY_SLOT_EN
    end else if (redirect) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      pcp4_q  <= RESET_PC_PLUS4;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomized + directed bench for id_stage against a behavioural decode model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrF = '0, PCPlus4F = '0, RD1D = '0, RD2D = '0, ALUOutM = '0;
  logic        StallD = 1'b0, FlushD = 1'b0, ForwardAD = 1'b0, ForwardBD = 1'b0;
  logic [31:0] InstrD, PCPlus4D, ImmExtD, PCBranchD, PCJumpD, PCJRD;
  logic        ValidD, PCSrcD, JumpD, JRD;
  logic [4:0]  RsD, RtD, RdD;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_instr, m_pc;
  logic        m_valid;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .FlushD(FlushD), .RD1D(RD1D), .RD2D(RD2D),
    .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ImmExtD(ImmExtD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD),
    .PCJumpD(PCJumpD), .JRD(JRD), .PCJRD(PCJRD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference decode of whatever the model says sits in D.
  function automatic logic [31:0] m_srca();
    return ForwardAD ? ALUOutM : RD1D;
  endfunction
  function automatic logic [31:0] m_srcb();
    return ForwardBD ? ALUOutM : RD2D;
  endfunction
  function automatic int m_op();
    return int'(m_instr >> 26);
  endfunction
  function automatic logic m_jump();
    return m_valid && (m_op() == 2 || m_op() == 3);
  endfunction
  function automatic logic m_jr();
    return m_valid && m_op() == 0 && (m_instr % 64) == 8;
  endfunction
  function automatic logic m_pcsrc();
    logic eq;
    eq = (m_srca() == m_srcb());
    return m_valid && ((m_op() == 4 && eq) || (m_op() == 5 && !eq));
  endfunction
  function automatic logic [31:0] m_imm();
    int v;
    v = int'(m_instr % 65536);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic check_all();
    check("InstrD",    InstrD,    m_instr);
    check("PCPlus4D",  PCPlus4D,  m_pc);
    check("ValidD",    {31'b0, ValidD}, {31'b0, m_valid});
    check("RsD",       {27'b0, RsD}, (m_instr >> 21) % 32);
    check("RtD",       {27'b0, RtD}, (m_instr >> 16) % 32);
    check("RdD",       {27'b0, RdD}, (m_instr >> 11) % 32);
    check("ImmExtD",   ImmExtD,   m_imm());
    check("PCSrcD",    {31'b0, PCSrcD}, {31'b0, m_pcsrc()});
    check("PCBranchD", PCBranchD, m_pc + m_imm() * 4);
    check("JumpD",     {31'b0, JumpD}, {31'b0, m_jump()});
    check("PCJumpD",   PCJumpD,   (m_pc & 32'hF000_0000) | ((m_instr % (1 << 26)) * 4));
    check("JRD",       {31'b0, JRD}, {31'b0, m_jr()});
    check("PCJRD",     PCJRD,     m_srca());
  endtask

  // Advance one clock: model takes the inputs present at the edge, outputs checked mid-cycle.
  task automatic step();
    logic [31:0] ni, np;
    logic        nv, redir;
    redir = m_pcsrc() || m_jump() || m_jr();
    ni = InstrF; np = PCPlus4F; nv = 1'b1;
    if (FlushD) begin
      ni = 0; nv = 0;
    end else if (StallD) begin
      ni = m_instr; np = m_pc; nv = m_valid;
    end else if (redir) begin
`ifndef DELAY_SLOT_EN
      ni = 0; nv = 0;
`endif
    end
    @(posedge clk);
    m_instr = ni; m_pc = np; m_valid = nv;
    @(negedge clk);
    check_all();
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pcp4);
    FlushD = 1'b1; StallD = 1'b0;
    step();
    FlushD = 1'b0;
    InstrF = instr; PCPlus4F = pcp4;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[31:26] = 6'b000100;
      1: r[31:26] = 6'b000101;
      2: r[31:26] = 6'b000010;
      3: r[31:26] = 6'b000011;
      4: begin r[31:26] = 6'b000000; r[5:0] = 6'b001000; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'd7;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_inputs();
    InstrF    = rand_instr();
    PCPlus4F  = $urandom;
    RD1D      = rand_val();
    RD2D      = rand_val();
    ALUOutM   = rand_val();
    ForwardAD = ($urandom_range(0, 2) == 0);
    ForwardBD = ($urandom_range(0, 2) == 0);
    StallD    = ($urandom_range(0, 4) == 0);
    FlushD    = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    m_instr = 0; m_pc = 32'h4; m_valid = 0;
    #12;
    check_all();
    check("rst_valid", {31'b0, ValidD}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      step();
    end

    // Asynchronous reset mid-run, then the first load.
    InstrF = 32'h2008_0005; PCPlus4F = 32'd8;
    StallD = 0; FlushD = 0; ForwardAD = 0; ForwardBD = 0;
    #2 rst_n = 1'b0;
    #1;
    m_instr = 0; m_pc = 32'h4; m_valid = 0;
    check("rst_instr", InstrD, 32'h0);
    check("rst_pc", PCPlus4D, 32'h4);
    check("rst_ctrl", {29'b0, PCSrcD, JumpD, JRD}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("load_instr", InstrD, 32'h2008_0005);
    check("load_pc", PCPlus4D, 32'd8);
    check("load_valid", {31'b0, ValidD}, 32'd1);

    // Taken beq and its wrong-path successor.
    RD1D = 0; RD2D = 0; ALUOutM = 32'h99;
    load(32'h1000_0003, 32'h10);
    check("beq_src", {31'b0, PCSrcD}, 32'd1);
    check("beq_tgt", PCBranchD, 32'h1C);
    InstrF = 32'h2009_0001; PCPlus4F = 32'h14;
    step();
`ifdef DELAY_SLOT_EN
    check("beq_slot", InstrD, 32'h2009_0001);
    check("beq_slot_v", {31'b0, ValidD}, 32'd1);
`else
    check("beq_squash", InstrD, 32'h0);
    check("beq_squash_v", {31'b0, ValidD}, 32'd0);
`endif

    // bne $1,$2,-1 with and without forwarding.
    RD1D = 5; RD2D = 5; ALUOutM = 7; ForwardAD = 1;
    load(32'h1422_FFFF, 32'h20);
    check("bne_fwd", {31'b0, PCSrcD}, 32'd1);
    check("bne_tgt", PCBranchD, 32'h1C);
    ForwardAD = 0;
    #1;
    check("bne_nofwd", {31'b0, PCSrcD}, 32'd0);

    // j and jr.
    load(32'h0800_0040, 32'hA000_0004);
    check("j_jump", {31'b0, JumpD}, 32'd1);
    check("j_tgt", PCJumpD, 32'hA000_0100);
    RD1D = 32'h44;
    load(32'h03E0_0008, 32'h30);
    check("jr_en", {31'b0, JRD}, 32'd1);
    check("jr_tgt", PCJRD, 32'h44);

    // Stall holds the jr and its redirect; flush beats stall.
    StallD = 1;
    for (int i = 0; i < 3; i++) begin
      InstrF = $urandom; PCPlus4F = $urandom;
      step();
      check("stall_instr", InstrD, 32'h03E0_0008);
      check("stall_jr", {31'b0, JRD}, 32'd1);
    end
    FlushD = 1;
    step();
    check("flush_stall", {31'b0, ValidD}, 32'd0);

    // Bubble gating: ValidD=0 never raises a control output.
    for (int i = 0; i < 20; i++) begin
      randomize_inputs();
      FlushD = 1;
      step();
      check("bubble_ctrl", {29'b0, PCSrcD, JumpD, JRD}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
